mxv_result_drain: RTL

Reader for the MxV result FIFO: after a start pulse it pops exactly `matrix_length` result words from the result FIFO and presents each on a valid/ready output stream. It signals `done` when the last word has been accepted. It sits at the consumer end of the result FIFO, opposite the processor chain that pushes into it.

---
 rtl/mxv_result_drain_if.sv | 27 ++
 rtl/mxv_result_drain.sv | 102 ++++++++++
 2 files changed

// File: rtl/mxv_result_drain_if.sv
// Handshake bundle for the MxV result drain: start/length request, result FIFO
// read port, valid/ready output stream and drain status.
interface mxv_result_drain_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   start;
  logic [WORD_LENGTH-1:0] matrix_length;
  logic                   fifo_empty;
  logic [WORD_LENGTH-1:0] fifo_data;
  logic                   fifo_pop;
  logic [WORD_LENGTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic [WORD_LENGTH-1:0] count;

  modport slave (
    input  start, matrix_length, fifo_empty, fifo_data, out_ready,
    output fifo_pop, out_data, out_valid, busy, done, count
  );

  modport master (
    output start, matrix_length, fifo_empty, fifo_data, out_ready,
    input  fifo_pop, out_data, out_valid, busy, done, count
  );
endinterface

// File: rtl/mxv_result_drain.sv
// Consumer end of the MxV result FIFO: pops matrix_length words one at a time
// and presents each on a valid/ready stream, pulsing done after the last one.
module mxv_result_drain #(
  parameter int WORD_LENGTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  mxv_result_drain_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [WORD_LENGTH-1:0] r_len;
  logic [WORD_LENGTH-1:0] r_count;
  logic [WORD_LENGTH-1:0] r_out_data;
  logic [WORD_LENGTH-1:0] w_count_inc;

  assign w_count_inc = r_count + WORD_LENGTH'(1);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode; the pop in POP is gated by fifo_empty so it never underflows
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.matrix_length == WORD_LENGTH'(0)) ? DONE : POP;
        end else begin
          w_next_state = IDLE;
        end
      end
      POP: begin
        if (!bus.fifo_empty) begin
          w_next_state = LATCH;
        end else begin
          w_next_state = POP;
        end
      end
      LATCH: w_next_state = SEND;
      SEND: begin
        if (bus.out_ready) begin
          w_next_state = (w_count_inc == r_len) ? DONE : POP;
        end else begin
          w_next_state = SEND;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // length latch, accepted-word counter and output data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len      <= WORD_LENGTH'(0);
      r_count    <= WORD_LENGTH'(0);
      r_out_data <= WORD_LENGTH'(0);
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_len   <= bus.matrix_length;
            r_count <= WORD_LENGTH'(0);
          end
        end
        LATCH: r_out_data <= bus.fifo_data;
        SEND: begin
          if (bus.out_ready) begin
            r_count <= w_count_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // outputs depend only on the state register (plus fifo_empty for the pop)
  assign bus.fifo_pop  = (r_state == POP) && !bus.fifo_empty;
  assign bus.out_valid = (r_state == SEND);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.out_data  = r_out_data;
  assign bus.count     = r_count;

endmodule
